// File: rtl/mouse_tracker_if.sv
// PS/2 byte stream in, decoded cursor/button state out for mouse_tracker.
// Optional MOUSE_WHEEL_EN adds the signed 4-bit wheel output.
interface mouse_tracker_if #(
   parameter int X_W = 8,
   parameter int Y_W = 7
);
   logic [7:0]     ps2_data;
   logic           ps2_valid;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           l_button;
   logic           r_button;
   logic           m_button;
   logic           l_click;
   logic           r_click;
   logic           pkt_valid;
   logic           sync_err;
`ifdef MOUSE_WHEEL_EN
   logic signed [3:0] wheel;
`endif

   modport master (
      output ps2_data, ps2_valid,
      input  x, y, l_button, r_button, m_button, l_click, r_click, pkt_valid, sync_err
`ifdef MOUSE_WHEEL_EN
      , wheel
`endif
   );

   modport slave (
      input  ps2_data, ps2_valid,
      output x, y, l_button, r_button, m_button, l_click, r_click, pkt_valid, sync_err
`ifdef MOUSE_WHEEL_EN
      , wheel
`endif
   );
endinterface

// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder with sync check, inter-byte timeout and clamped cursor.
// MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets and the wheel output.
module mouse_tracker #(
   parameter int X_MAX          = 160,
   parameter int Y_MAX          = 120,
   parameter int X_W            = 8,
   parameter int Y_W            = 7,
   parameter int SPEED_SHIFT    = 0,
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input logic             CLOCK_50,
   input logic             reset,
   mouse_tracker_if.slave  bus
);
   localparam int MW = (X_W > Y_W) ? X_W : Y_W;
   // Wide enough for a coordinate plus a full 9-bit delta without overflow.
   localparam int CW = (MW + 2 > 10) ? MW + 2 : 10;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic signed [CW-1:0] X_TOP = CW'(X_MAX - 1);
   localparam logic signed [CW-1:0] Y_TOP = CW'(Y_MAX - 1);

   typedef enum logic [2:0] {
      S_B0,
      S_B1,
      S_B2,
`ifdef MOUSE_WHEEL_EN
      S_B3,
`endif
      S_APPLY
   } state_t;

   state_t          state_q;
   logic [TW-1:0]   tcnt_q;
   logic [2:0]      btn_pend_q;
   logic            xs_q, ys_q, xo_q, yo_q;
   logic [7:0]      xlo_q, ylo_q;
   logic [X_W-1:0]  x_q;
   logic [Y_W-1:0]  y_q;
   logic            l_q, r_q, m_q, lclk_q, rclk_q, pv_q, se_q;
`ifdef MOUSE_WHEEL_EN
   logic [3:0]      wlo_q;
   logic signed [3:0] wheel_q;
`endif

   logic signed [8:0]    dx_raw, dy_raw, dx_s, dy_s;
   logic signed [CW-1:0] x_sum, y_sum;
   logic [X_W-1:0]       x_d;
   logic [Y_W-1:0]       y_d;
   logic                 take_b0, b0_ok, b0_bad, timed_out;

   always_comb begin
      dx_raw = xo_q ? 9'sd0 : $signed({xs_q, xlo_q});
      dy_raw = yo_q ? 9'sd0 : $signed({ys_q, ylo_q});
      dx_s   = dx_raw >>> SPEED_SHIFT;
      dy_s   = dy_raw >>> SPEED_SHIFT;
      // PS/2 +Y points up while screen rows grow downward.
      x_sum  = $signed({{(CW-X_W){1'b0}}, x_q}) + $signed({{(CW-9){dx_s[8]}}, dx_s});
      y_sum  = $signed({{(CW-Y_W){1'b0}}, y_q}) - $signed({{(CW-9){dy_s[8]}}, dy_s});
      x_d    = (x_sum < 0) ? '0 : (x_sum > X_TOP) ? X_TOP[X_W-1:0] : x_sum[X_W-1:0];
      y_d    = (y_sum < 0) ? '0 : (y_sum > Y_TOP) ? Y_TOP[Y_W-1:0] : y_sum[Y_W-1:0];
   end

   assign take_b0   = (state_q == S_B0) || (state_q == S_APPLY);
   assign b0_ok     = bus.ps2_valid &&  bus.ps2_data[3];
   assign b0_bad    = bus.ps2_valid && !bus.ps2_data[3];
   assign timed_out = (tcnt_q >= TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= S_B0;
         tcnt_q     <= '0;
         btn_pend_q <= '0;
         {xs_q, ys_q, xo_q, yo_q} <= '0;
         xlo_q      <= '0;
         ylo_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         {l_q, r_q, m_q, lclk_q, rclk_q, pv_q, se_q} <= '0;
`ifdef MOUSE_WHEEL_EN
         wlo_q      <= '0;
         wheel_q    <= '0;
`endif
      end else begin
         lclk_q <= 1'b0;
         rclk_q <= 1'b0;
         pv_q   <= 1'b0;
         se_q   <= 1'b0;
         case (state_q)
            S_B0: ;
            S_B1, S_B2
`ifdef MOUSE_WHEEL_EN
            , S_B3
`endif
            : begin
               if (bus.ps2_valid) begin
                  tcnt_q <= '0;
                  if (state_q == S_B1) begin
                     xlo_q   <= bus.ps2_data;
                     state_q <= S_B2;
                  end else if (state_q == S_B2) begin
                     ylo_q   <= bus.ps2_data;
`ifdef MOUSE_WHEEL_EN
                     state_q <= S_B3;
`else
                     state_q <= S_APPLY;
`endif
                  end else begin
`ifdef MOUSE_WHEEL_EN
                     wlo_q   <= bus.ps2_data[3:0];
`endif
                     state_q <= S_APPLY;
                  end
               end else if (timed_out) begin
                  tcnt_q  <= '0;
                  se_q    <= 1'b1;
                  state_q <= S_B0;
               end else begin
                  tcnt_q  <= tcnt_q + TW'(1);
               end
            end
            S_APPLY: begin
               x_q     <= x_d;
               y_q     <= y_d;
               l_q     <= btn_pend_q[0];
               r_q     <= btn_pend_q[1];
               m_q     <= btn_pend_q[2];
               lclk_q  <= btn_pend_q[0] & ~l_q;
               rclk_q  <= btn_pend_q[1] & ~r_q;
               pv_q    <= 1'b1;
`ifdef MOUSE_WHEEL_EN
               wheel_q <= $signed(wlo_q);
`endif
               state_q <= S_B0;
            end
            default: state_q <= S_B0;
         endcase

         // The apply cycle doubles as a byte-0 slot, so back-to-back packets lose nothing.
         if (take_b0) begin
            tcnt_q <= '0;
            if (b0_ok) begin
               btn_pend_q <= bus.ps2_data[2:0];
               xs_q       <= bus.ps2_data[4];
               ys_q       <= bus.ps2_data[5];
               xo_q       <= bus.ps2_data[6];
               yo_q       <= bus.ps2_data[7];
               state_q    <= S_B1;
            end else if (b0_bad) begin
               se_q       <= 1'b1;
            end
         end
      end
   end

   assign bus.x         = x_q;
   assign bus.y         = y_q;
   assign bus.l_button  = l_q;
   assign bus.r_button  = r_q;
   assign bus.m_button  = m_q;
   assign bus.l_click   = lclk_q;
   assign bus.r_click   = rclk_q;
   assign bus.pkt_valid = pv_q;
   assign bus.sync_err  = se_q;
`ifdef MOUSE_WHEEL_EN
   assign bus.wheel     = wheel_q;
`endif
endmodule
